// File: rtl/decoder_scan_active_low.sv
// Registered N-to-2^N one-cold decoder with enable and a self-timed
// scan mode (dwell + blanking) for display/keypad strobes.
module decoder_scan_active_low #(
  parameter int N     = 3,
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        sel,
  input  logic [N-1:0]        last,
  output logic [0:(1<<N)-1]   D,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int W    = 1 << N;
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DW_C  = CW'(DWELL);
  localparam logic [CW-1:0] BL_C  = CW'(BLANK);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN_ON,
    SCAN_BLANK
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [0:W-1]   d_q, d_d;
  logic [N-1:0]   idx_q, idx_d;
  logic           wrap_q, wrap_d;

  logic           adv_wrap;
  logic [N-1:0]   adv_idx;

  function automatic logic [0:W-1] cold(input logic [N-1:0] i);
    logic [0:W-1] r;
    for (int j = 0; j < W; j++) begin
      r[j] = (i != N'(j));
    end
    return r;
  endfunction

  // last is sampled here, so a shrink below idx wraps at the next step
  assign adv_wrap = (idx_q >= last);
  assign adv_idx  = adv_wrap ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      d_d     = '1;
    end else if (!mode) begin
      state_d = DIRECT;
      cnt_d   = '0;
      d_d     = cold(sel);
      idx_d   = sel;
    end else begin
      unique case (state_q)
        IDLE, DIRECT: begin
          state_d = SCAN_ON;
          cnt_d   = ONE_C;
          idx_d   = '0;
          d_d     = cold('0);
        end
        SCAN_ON: begin
          if (cnt_q < DW_C) begin
            cnt_d = cnt_q + ONE_C;
          end else if (BLANK > 0) begin
            state_d = SCAN_BLANK;
            cnt_d   = ONE_C;
            d_d     = '1;
          end else begin
            state_d = SCAN_ON;
            cnt_d   = ONE_C;
            idx_d   = adv_idx;
            d_d     = cold(adv_idx);
            wrap_d  = adv_wrap;
          end
        end
        SCAN_BLANK: begin
          if (cnt_q < BL_C) begin
            cnt_d = cnt_q + ONE_C;
          end else begin
            state_d = SCAN_ON;
            cnt_d   = ONE_C;
            idx_d   = adv_idx;
            d_d     = cold(adv_idx);
            wrap_d  = adv_wrap;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          d_d     = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '1;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
    end
  end

  assign D    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_active_low.sv
// Randomized bench for decoder_scan_active_low: phase-based model of two
// builds (BLANK=1 and BLANK=0) plus hand-computed literal checks.
module tb_decoder_scan_active_low;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] sel = '0;
  logic [2:0] last = '0;

  logic [0:7] d_a, d_b;
  logic [2:0] idx_a, idx_b;
  logic       wrap_a, wrap_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_scan_active_low #(.N(3), .DWELL(4), .BLANK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel(sel), .last(last), .D(d_a), .idx(idx_a), .wrap(wrap_a)
  );

  decoder_scan_active_low #(.N(3), .DWELL(2), .BLANK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel(sel), .last(last), .D(d_b), .idx(idx_b), .wrap(wrap_b)
  );

  function automatic logic [0:7] cold(input int i);
    logic [0:7] r;
    r = '1;
    r[i] = 1'b0;
    return r;
  endfunction

  function automatic int dwell_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int blank_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", nm, $time);
  endtask

  // Model: a scan is a running index plus a phase 0..DWELL+BLANK-1
  bit         scan_m[2];
  int         cur_m[2];
  int         ph_m[2];
  logic [2:0] idx_m[2];
  logic       wrap_m[2];
  logic [0:7] d_m[2];

  task automatic step(input int k);
    int p;
    p = dwell_of(k) + blank_of(k);
    if (!rst_n) begin
      scan_m[k] = 0; idx_m[k] = 0; wrap_m[k] = 0; d_m[k] = '1;
    end else if (!en) begin
      scan_m[k] = 0; wrap_m[k] = 0; d_m[k] = '1;
    end else if (!mode) begin
      scan_m[k] = 0; idx_m[k] = sel; wrap_m[k] = 0; d_m[k] = cold(sel);
    end else begin
      wrap_m[k] = 0;
      if (!scan_m[k]) begin
        scan_m[k] = 1; cur_m[k] = 0; ph_m[k] = 0;
      end else begin
        ph_m[k]++;
        if (ph_m[k] == p) begin
          ph_m[k] = 0;
          wrap_m[k] = (cur_m[k] >= int'(last));
          cur_m[k] = wrap_m[k] ? 0 : cur_m[k] + 1;
        end
      end
      idx_m[k] = 3'(cur_m[k]);
      d_m[k] = (ph_m[k] < dwell_of(k)) ? cold(cur_m[k]) : 8'hFF;
    end
  endtask

  always begin
    @(posedge clk);
    step(0);
    step(1);
    #1;
    chk("model_D_a", d_a, d_m[0]);
    chk("model_idx_a", {5'b0, idx_a}, {5'b0, idx_m[0]});
    chk("model_wrap_a", {7'b0, wrap_a}, {7'b0, wrap_m[0]});
    chk("onecold_a", {7'b0, ($countones(~d_a) <= 1)}, 8'd1);
    chk("model_D_b", d_b, d_m[1]);
    chk("model_idx_b", {5'b0, idx_b}, {5'b0, idx_m[1]});
    chk("model_wrap_b", {7'b0, wrap_b}, {7'b0, wrap_m[1]});
    chk("onecold_b", {7'b0, ($countones(~d_b) <= 1)}, 8'd1);
  end

  task automatic wait_wrap(input bit use_b, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(use_b ? wrap_b : wrap_a) && n < 300);
    if (n >= 300) timeout(use_b ? "wrap_b" : "wrap_a");
  endtask

  task automatic wait_idx(input logic [2:0] v, input bit eq,
                          input string nm);
    int n;
    n = 0;
    while (((idx_a == v) != eq) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) timeout(nm);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    logic [0:7] exp;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_D", d_a, 8'hFF);
    chk("reset_idx", {5'b0, idx_a}, 8'd0);
    chk("reset_wrap", {7'b0, wrap_a}, 8'd0);

    @(negedge clk);
    en = 1; mode = 0; sel = 5;
    after_edge();
    chk("direct5_D", d_a, 8'b11111011);
    chk("direct5_idx", {5'b0, idx_a}, 8'd5);
    @(negedge clk);
    sel = 0;
    after_edge();
    chk("direct0_D", d_a, 8'b01111111);
    @(negedge clk);
    en = 0;
    after_edge();
    chk("disable_D", d_a, 8'hFF);
    chk("disable_idx", {5'b0, idx_a}, 8'd0);

    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      en = c[2];
      sel = {1'b0, c[0], c[1]};
      after_edge();
      exp = en ? cold(int'(sel)) : 8'hFF;
      chk("sweep_D", d_a, exp);
    end

    @(negedge clk);
    en = 1; mode = 1; last = 2;
    after_edge();
    chk("scan_entry_D", d_a, 8'b01111111);
    chk("scan_entry_idx", {5'b0, idx_a}, 8'd0);
    chk("scan_entry_wrap", {7'b0, wrap_a}, 8'd0);
    wait_wrap(0, n);
    chk("wrap_D", d_a, 8'b01111111);
    wait_wrap(0, n);
    chk("period_a", 8'(n), 8'd15);
    wait_wrap(1, n);
    wait_wrap(1, n);
    chk("period_b", 8'(n), 8'd6);

    @(negedge clk);
    last = 7;
    wait_idx(3'd4, 1, "idx_is_4");
    last = 1;
    wait_idx(3'd4, 0, "leave_4");
    chk("dyn_idx0", {5'b0, idx_a}, 8'd0);
    chk("dyn_wrap", {7'b0, wrap_a}, 8'd1);
    wait_idx(3'd0, 0, "leave_0");
    chk("dyn_idx1", {5'b0, idx_a}, 8'd1);
    wait_idx(3'd1, 0, "leave_1");
    chk("dyn_idx0b", {5'b0, idx_a}, 8'd0);
    chk("dyn_wrap_b", {7'b0, wrap_a}, 8'd1);

    @(negedge clk);
    mode = 0; sel = 6;
    after_edge();
    chk("switch_D", d_a, 8'b11111101);
    chk("switch_idx", {5'b0, idx_a}, 8'd6);
    @(negedge clk);
    mode = 1;
    after_edge();
    chk("restart_D", d_a, 8'b01111111);
    chk("restart_idx", {5'b0, idx_a}, 8'd0);
    chk("restart_wrap", {7'b0, wrap_a}, 8'd0);

    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("async_rst_D", d_a, 8'hFF);
    chk("async_rst_idx", {5'b0, idx_a}, 8'd0);
    chk("async_rst_wrap", {7'b0, wrap_a}, 8'd0);
    chk("async_rst_D_b", d_b, 8'hFF);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en = ($urandom_range(15) != 0);
      if ($urandom_range(31) == 0) mode = ~mode;
      sel = 3'($urandom);
      if ($urandom_range(63) == 0) last = 3'($urandom);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
